// File: rtl/mmio_int_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_int_ctrl
//   Memory-mapped interrupt controller for the Minisys MMIO peripheral space.
//   It collects up to eight peripheral interrupt lines into one prioritised
//   request to the CPU and runs a request / acknowledge / end-of-interrupt
//   (EOI) handshake. Source index 0 has the highest priority.
//
//   Register map (only addr_i[15:0] is decoded, rdata_o[31:16] reads 0):
//     0xFC80 PEND  R: pending vector     W: 1 clears an edge-mode bit
//     0xFC82 MASK  R/W, 1 = enabled, resets to 0
//     0xFC84 MODE  R/W, 1 = edge, 0 = level, resets to all 1
//     0xFC86 STAT  R: {state[9:8], ovf[4], in_service[3], cur_id[2:0]}
//                  W: EOI (wdata[4]=1 also clears ovf when the timeout
//                     feature is built in)
//
//   Optional feature (compile-time macro INTC_ACK_TIMEOUT_EN):
//     A request left unacknowledged for TIMEOUT cycles is dropped, the sticky
//     ovf flag is set and the still-pending source is re-arbitrated. Without
//     the macro a request waits indefinitely and ovf reads 0.
//
//   Ports:
//     clk_i       system clock, rising edge
//     rst_i       synchronous active-high reset
//     we_i        bus write strobe
//     be_i        byte enables (ignored: every write is 16 bits wide)
//     addr_i      bus address
//     wdata_i     bus write data
//     rdata_o     combinational read data, 0 for unmapped addresses
//     irq_src_i   raw active-high interrupt lines
//     int_ack_i   one-cycle CPU acknowledge
//     int_req_o   interrupt request to the CPU
//     int_id_o    index of the requesting / in-service source
// -----------------------------------------------------------------------------
module mmio_int_ctrl #(
   parameter int NSRC    = 6,
   parameter int TIMEOUT = 1024
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            we_i,
   input  logic [3:0]      be_i,
   input  logic [31:0]     addr_i,
   input  logic [31:0]     wdata_i,
   output logic [31:0]     rdata_o,
   input  logic [NSRC-1:0] irq_src_i,
   input  logic            int_ack_i,
   output logic            int_req_o,
   output logic [2:0]      int_id_o
);

   localparam logic [15:0] A_PEND = 16'hFC80;
   localparam logic [15:0] A_MASK = 16'hFC82;
   localparam logic [15:0] A_MODE = 16'hFC84;
   localparam logic [15:0] A_STAT = 16'hFC86;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_SERV = 2'd2;

   logic [NSRC-1:0] src_q, src_prev_q;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] mask_q, mode_q;
   logic [1:0]      state_q, state_d;
   logic [2:0]      cur_id_q, cur_id_d;
   logic            in_service_q, in_service_d;
   logic            ovf;

   logic            wr_pend, wr_mask, wr_mode, wr_stat;
   logic [NSRC-1:0] rise, w1c, ack_clr, eligible, cur_oh, edge_next;
   logic [2:0]      winner;
   logic            timed_out;

   // Byte enables and the upper address/data halves carry no information here.
   logic unused_bits;
   assign unused_bits = ^{be_i, addr_i[31:16], wdata_i};

   // ---------------------------------------------------------------------------
   // Bus write decode
   // ---------------------------------------------------------------------------
   assign wr_pend = we_i && (addr_i[15:0] == A_PEND);
   assign wr_mask = we_i && (addr_i[15:0] == A_MASK);
   assign wr_mode = we_i && (addr_i[15:0] == A_MODE);
   assign wr_stat = we_i && (addr_i[15:0] == A_STAT);

   // ---------------------------------------------------------------------------
   // Capture and arbitration
   // ---------------------------------------------------------------------------
   assign rise     = src_q & ~src_prev_q;
   assign w1c      = wr_pend ? wdata_i[NSRC-1:0] : '0;
   assign eligible = pend_q & mask_q;
   assign cur_oh   = NSRC'(1) << cur_id_q;

   // Edge-mode bits: a new edge wins over a same-cycle clear (W1C or ack).
   // Level-mode bits simply follow the registered line.
   assign edge_next = (pend_q & ~(w1c | ack_clr)) | rise;
   assign pend_d    = (mode_q & edge_next) | (~mode_q & src_q);

   // Lowest set index wins: scan downwards so the last hit is the smallest.
   always_comb begin
      winner = 3'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner = 3'(i);
      end
   end

   // ---------------------------------------------------------------------------
   // Optional acknowledge timeout
   // ---------------------------------------------------------------------------
`ifdef INTC_ACK_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;

   // The counter restarts from 0 on every entry into REQ.
   assign cnt_d     = (state_q == S_REQ) ? cnt_q + CW'(1) : '0;
   assign timed_out = (state_q == S_REQ) && (cnt_q == CW'(TIMEOUT - 1));

   // A timeout in the same cycle as a clearing write leaves ovf set.
   always_comb begin
      ovf_d = ovf_q;
      if (wr_stat && wdata_i[4]) ovf_d = 1'b0;
      if (timed_out && !int_ack_i) ovf_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign timed_out = 1'b0;
   assign ovf       = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Request / acknowledge / EOI sequencer
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned in this block gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      cur_id_d     = cur_id_q;
      in_service_d = in_service_q;
      ack_clr      = '0;
      case (state_q)
         S_IDLE: begin
            if (|eligible) begin
               cur_id_d = winner;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            // cur_id is frozen here: a higher-priority arrival waits its turn.
            if (int_ack_i) begin
               ack_clr      = cur_oh;
               in_service_d = 1'b1;
               state_d      = S_SERV;
            end else if (!(|(eligible & cur_oh)) || timed_out) begin
               cur_id_d = 3'd0;
               state_d  = S_IDLE;
            end
         end
         S_SERV: begin
            if (wr_stat) begin
               in_service_d = 1'b0;
               cur_id_d     = 3'd0;
               state_d      = S_IDLE;
            end
         end
         default: begin
            cur_id_d     = 3'd0;
            in_service_d = 1'b0;
            state_d      = S_IDLE;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge value of every other register, regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_q        <= '0;
         src_prev_q   <= '0;
         pend_q       <= '0;
         mask_q       <= '0;
         mode_q       <= '1;
         state_q      <= S_IDLE;
         cur_id_q     <= 3'd0;
         in_service_q <= 1'b0;
      end else begin
         src_q        <= irq_src_i;
         src_prev_q   <= src_q;
         pend_q       <= pend_d;
         if (wr_mask) mask_q <= wdata_i[NSRC-1:0];
         if (wr_mode) mode_q <= wdata_i[NSRC-1:0];
         state_q      <= state_d;
         cur_id_q     <= cur_id_d;
         in_service_q <= in_service_d;
      end
   end

   assign int_req_o = (state_q == S_REQ);
   assign int_id_o  = cur_id_q;

   // ---------------------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------------------
   always_comb begin
      rdata_o = '0;
      case (addr_i[15:0])
         A_PEND:  rdata_o = {{(32 - NSRC){1'b0}}, pend_q};
         A_MASK:  rdata_o = {{(32 - NSRC){1'b0}}, mask_q};
         A_MODE:  rdata_o = {{(32 - NSRC){1'b0}}, mode_q};
         A_STAT:  rdata_o = {22'd0, state_q, 3'd0, ovf, in_service_q, cur_id_q};
         default: rdata_o = '0;
      endcase
   end

endmodule

// File: tb/tb_mmio_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_int_ctrl
//   Directed self-checking bench for mmio_int_ctrl. Expected values are pushed
//   to a scoreboard queue as stimulus is driven and popped when the matching
//   DUT output is sampled (1 ns after the rising edge).
//   Build with INTC_ACK_TIMEOUT_EN defined to exercise the timeout path with
//   TIMEOUT = 16.
// -----------------------------------------------------------------------------
module tb_mmio_int_ctrl;

   localparam int NSRC = 6;
`ifdef INTC_ACK_TIMEOUT_EN
   localparam int TB_TIMEOUT = 16;
`else
   localparam int TB_TIMEOUT = 1024;
`endif

   localparam logic [15:0] A_PEND = 16'hFC80;
   localparam logic [15:0] A_MASK = 16'hFC82;
   localparam logic [15:0] A_MODE = 16'hFC84;
   localparam logic [15:0] A_STAT = 16'hFC86;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            we_i;
   logic [3:0]      be_i;
   logic [31:0]     addr_i;
   logic [31:0]     wdata_i;
   logic [31:0]     rdata_o;
   logic [NSRC-1:0] irq_src_i;
   logic            int_ack_i;
   logic            int_req_o;
   logic [2:0]      int_id_o;

   mmio_int_ctrl #(.NSRC(NSRC), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (we_i),
      .be_i      (be_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .rdata_o   (rdata_o),
      .irq_src_i (irq_src_i),
      .int_ack_i (int_ack_i),
      .int_req_o (int_req_o),
      .int_id_o  (int_id_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic observe(input logic [31:0] obs);
      exp_t x;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_underflow: observed %h with no expectation", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
         end
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      we_i    = 1'b1;
      addr_i  = {16'h0000, a};
      wdata_i = d;
      tick();
      we_i    = 1'b0;
      wdata_i = '0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
      expect_val(tag, e);
      addr_i = a;
      #1;
      observe(rdata_o);
   endtask

   task automatic req_chk(input string tag, input logic req, input logic [2:0] id);
      expect_val({tag, "_req"}, {31'd0, req});
      expect_val({tag, "_id"}, {29'd0, id});
      observe({31'd0, int_req_o});
      observe({29'd0, int_id_o});
   endtask

   task automatic req_only(input string tag, input logic req);
      expect_val({tag, "_req"}, {31'd0, req});
      observe({31'd0, int_req_o});
   endtask

   // One-cycle pulse on the given lines, then two more edges so the request
   // (if eligible) is visible on int_req_o.
   task automatic pulse_to_req(input logic [NSRC-1:0] v);
      irq_src_i = v;
      tick();
      irq_src_i = '0;
      tick();
      tick();
   endtask

   task automatic ack();
      int_ack_i = 1'b1;
      tick();
      int_ack_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i     = 1'b1;
      we_i      = 1'b0;
      be_i      = 4'hF;
      addr_i    = '0;
      wdata_i   = '0;
      irq_src_i = '0;
      int_ack_i = 1'b0;
      repeat (3) tick();
      rst_i = 1'b0;

      // Reset state
      req_chk("rst", 1'b0, 3'd0);
      rd_chk("rst_pend", {16'h0, A_PEND}, 32'h0000_0000);
      rd_chk("rst_mask", {16'h0, A_MASK}, 32'h0000_0000);
      rd_chk("rst_mode", {16'h0, A_MODE}, 32'h0000_003F);
      tick();
      rd_chk("rst_stat", {16'h0, A_STAT}, 32'h0000_0000);

      // Unused register bits, unmapped addresses, upper address bits ignored
      wr(A_MASK, 32'hFFFF_FFFF);
      rd_chk("mask_trunc", {16'h0, A_MASK}, 32'h0000_003F);
      rd_chk("unmapped_fc81", 32'h0000_FC81, 32'h0000_0000);
      rd_chk("unmapped_fc88", 32'h0000_FC88, 32'h0000_0000);
      tick();
      rd_chk("alias_hi_addr", 32'h1234_FC82, 32'h0000_003F);

      // ack and EOI in IDLE are ignored
      ack();
      wr(A_STAT, 32'h0);
      req_only("idle_ign", 1'b0);
      rd_chk("idle_ign_stat", {16'h0, A_STAT}, 32'h0000_0000);

      // Single edge source: request two edges after capture
      irq_src_i = 6'h04;
      expect_val("t1_early0_req", 32'd0);
      tick();
      irq_src_i = '0;
      observe({31'd0, int_req_o});
      expect_val("t1_early1_req", 32'd0);
      tick();
      observe({31'd0, int_req_o});
      tick();
      req_chk("t1", 1'b1, 3'd2);
      rd_chk("t1_pend", {16'h0, A_PEND}, 32'h0000_0004);
      ack();
      req_chk("t1_ack", 1'b0, 3'd2);
      rd_chk("t1_stat_serv", {16'h0, A_STAT}, 32'h0000_020A);
      rd_chk("t1_pend_clr", {16'h0, A_PEND}, 32'h0000_0000);
      wr(A_STAT, 32'h0);
      rd_chk("t1_stat_eoi", {16'h0, A_STAT}, 32'h0000_0000);

      // Two simultaneous sources: lowest index first
      pulse_to_req(6'h12);
      req_chk("t2_first", 1'b1, 3'd1);
      ack();
      rd_chk("t2_stat", {16'h0, A_STAT}, 32'h0000_0209);
      wr(A_STAT, 32'h0);
      req_only("t2_eoi", 1'b0);
      tick();
      req_chk("t2_second", 1'b1, 3'd4);
      ack();

      // New event during SERV waits for EOI, then requests one cycle later
      pulse_to_req(6'h01);
      tick();
      req_chk("t5_serv_hold", 1'b0, 3'd4);
      rd_chk("t5_pend", {16'h0, A_PEND}, 32'h0000_0001);
      wr(A_STAT, 32'h0);
      req_only("t5_eoi", 1'b0);
      tick();
      req_chk("t5_after_eoi", 1'b1, 3'd0);
      ack();
      wr(A_STAT, 32'h0);

      // Level mode: W1C has no effect, dropped line withdraws the request
      wr(A_MODE, 32'h0);
      wr(A_MASK, 32'h1);
      irq_src_i = 6'h01;
      tick();
      tick();
      tick();
      req_chk("t3_level", 1'b1, 3'd0);
      wr(A_PEND, 32'h1);
      rd_chk("t3_w1c_ign", {16'h0, A_PEND}, 32'h0000_0001);
      req_only("t3_still", 1'b1);
      irq_src_i = '0;
      tick();
      tick();
      tick();
      req_only("t3_drop", 1'b0);
      rd_chk("t3_stat", {16'h0, A_STAT}, 32'h0000_0000);
      wr(A_MODE, 32'h3F);

      // Masked source still latches; unmasking raises it; W1C withdraws it
      wr(A_MASK, 32'h0);
      pulse_to_req(6'h08);
      tick();
      req_only("t4_masked", 1'b0);
      rd_chk("t4_pend", {16'h0, A_PEND}, 32'h0000_0008);
      wr(A_MASK, 32'h08);
      tick();
      req_chk("t4_unmask", 1'b1, 3'd3);
      wr(A_PEND, 32'h08);
      tick();
      req_only("t4_withdrawn", 1'b0);
      rd_chk("t4_pend_clr", {16'h0, A_PEND}, 32'h0000_0000);

      // Edge set and W1C in the same cycle: set wins
      irq_src_i = 6'h20;
      tick();
      irq_src_i = '0;
      wr(A_PEND, 32'h20);
      rd_chk("setwin_pend", {16'h0, A_PEND}, 32'h0000_0020);
      wr(A_PEND, 32'h20);
      rd_chk("setwin_clr", {16'h0, A_PEND}, 32'h0000_0000);

      // Unacknowledged request
      wr(A_MASK, 32'h01);
      pulse_to_req(6'h01);
      req_chk("t6_req", 1'b1, 3'd0);
`ifdef INTC_ACK_TIMEOUT_EN
      repeat (TB_TIMEOUT - 1) tick();
      req_only("t6_before_to", 1'b1);
      tick();
      req_only("t6_timeout", 1'b0);
      rd_chk("t6_ovf", {16'h0, A_STAT}, 32'h0000_0010);
      tick();
      req_chk("t6_rereq", 1'b1, 3'd0);
      wr(A_STAT, 32'h10);
      rd_chk("t6_ovf_clr", {16'h0, A_STAT}, 32'h0000_0100);
`else
      repeat (40) tick();
      req_chk("t6_wait", 1'b1, 3'd0);
      rd_chk("t6_no_ovf", {16'h0, A_STAT}, 32'h0000_0100);
`endif
      ack();
      ack();
      rd_chk("t6_serv_ack_ign", {16'h0, A_STAT}, 32'h0000_0208);
      wr(A_STAT, 32'h0);

      // Reset mid-sequence abandons the request
      pulse_to_req(6'h01);
      req_only("mid_req", 1'b1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      req_chk("mid_rst", 1'b0, 3'd0);
      rd_chk("mid_mask", {16'h0, A_MASK}, 32'h0000_0000);
      rd_chk("mid_mode", {16'h0, A_MODE}, 32'h0000_003F);
      tick();
      rd_chk("mid_pend", {16'h0, A_PEND}, 32'h0000_0000);
      rd_chk("mid_stat", {16'h0, A_STAT}, 32'h0000_0000);

      vectors++;
      assert (sb.size() == 0) else begin
         miscompares++;
         $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mmio_int_ctrl.md
Name: mmio_int_ctrl

Overview:
- Memory-mapped interrupt controller for the Minisys MMIO peripheral space.
- Collects peripheral interrupt lines (timer_int[1:0], keyboard pressed, PWM/watchdog events, spares) into one prioritised request to the CPU.
- Runs a request/acknowledge/end-of-interrupt sequence.
- Sits beside the peripheral MMIO block on the same CPU data bus, at MMIO addresses 0xFC80–0xFC86.

Parameters:
- NSRC, 6, number of interrupt sources (1..8); index 0 is the highest priority.
- TIMEOUT, 1024, cycles int_req may stay unacknowledged (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  bus write strobe, qualified by an address match.
- be  in  4  byte enables; ignored, every write is a 16-bit write of wdata[15:0].
- addr  in  32  bus address; only addr[15:0] is decoded.
- wdata  in  32  bus write data.
- rdata  out  32  combinational read data; 0 for unmapped addresses.
- irq_src  in  NSRC  raw interrupt lines from peripherals; active-high.
- int_ack  in  1  one-cycle CPU acknowledge of the current request.
- int_req  out  1  interrupt request to the CPU.
- int_id  out  3  index of the requesting or in-service source.

Behaviour:
- Register map (rdata[31:16] always reads 0):
  - 0xFC80 PEND: read gives the pending vector; a write of 1 to an edge-mode bit clears it.
  - 0xFC82 MASK: R/W; 1 = enabled; reset 0.
  - 0xFC84 MODE: R/W; bit i = 1 means edge mode, 0 means level mode; reset all 1.
  - 0xFC86 STAT: read gives {state[1:0] at [9:8], ovf at [4], in_service at [3], cur_id at [2:0]}; any write is an EOI.
- Source capture:
  - Each irq_src bit is registered once to form src_q.
  - Edge mode: src_q rising edge (current 1, previous 0) sets pend[i].
  - Edge mode, set and W1C in the same cycle: set wins.
  - Level mode: pend[i] = src_q[i] every cycle; W1C has no effect.
  - MASK does not stop latching; it only gates arbitration.
- Arbitration: eligible = pend & MASK; the winner is the lowest set index.
- FSM states IDLE=0, REQ=1, SERV=2:
  - IDLE: if eligible != 0, latch cur_id = winner and go to REQ. int_req rises the cycle after eligibility is seen (2 cycles after an irq_src edge).
  - REQ: int_req=1 and int_id=cur_id.
    - If int_ack: clear pend[cur_id] (edge mode), set in_service=1, go to SERV.
    - Else if pend[cur_id] & MASK[cur_id] has dropped (spurious): go to IDLE, int_req=0.
    - A higher-priority source arriving in REQ does not replace cur_id.
  - SERV: int_req=0; int_id holds cur_id; other events stay pending.
    - An EOI write clears in_service and returns to IDLE.
    - A new request can be raised in the cycle after the EOI.
  - EOI written in IDLE or REQ is ignored.
  - int_ack received in IDLE or SERV is ignored.
- Reset: int_req=0, int_id=0, pend=0, MASK=0, MODE=all 1, state IDLE, in_service=0, ovf=0, src_q=0. A reset mid-sequence abandons the request immediately.
- NSRC<8: unused bits of PEND, MASK and MODE read 0, and writes to them are ignored.

Optional Feature:
- Macro INTC_ACK_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ.
  - If TIMEOUT cycles pass without int_ack, return to IDLE, drop int_req, and set the sticky ovf flag (STAT[4]).
  - The pend bit is kept, so arbitration re-requests.
  - A write to STAT with wdata[4]=1 clears ovf; this is in addition to its EOI effect.
- Undefined: REQ waits indefinitely; ovf reads 0.

Test Plan:
- MASK=0x3F, pulse irq_src[2] for one cycle → int_req=1 with int_id=2 two cycles later; int_ack → int_req=0, STAT=0x0208 +cur_id 2 (i.e. 0x020A); EOI → STAT=0x0000.
- MASK=0x3F, raise irq_src[4] and irq_src[1] in the same cycle → int_id=1 first; after ack+EOI → int_id=4.
- MODE=0x00, MASK=0x01, hold irq_src[0] high, then drop it before ack → int_req falls and the FSM returns to IDLE; write PEND=0x01 while the level is high → PEND stays 0x01.
- MASK=0x00, pulse irq_src[3] → PEND=0x08 and int_req=0; write MASK=0x08 → int_req with int_id=3; write PEND=0x08 while in REQ → request withdrawn.
- In SERV, pulse irq_src[0] → no int_req until EOI; int_req rises with int_id=0 one cycle after the EOI.
- With INTC_ACK_TIMEOUT_EN and TIMEOUT=16, no int_ack → after 16 cycles int_req drops, STAT[4]=1, and the request re-asserts; write STAT=0x10 → ovf=0.
